// File: rtl/uart_rx_parity_checker.sv
// UART RX parity checker: one check per parity slot at the oversampling mid-point.
// Define UART_RX_PAR_ERR_CNT_EN to build the saturating failed-check counter.
module uart_rx_parity_checker #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int EDGE_CNT_WIDTH = 5,
    parameter int ERR_CNT_WIDTH  = 8,
    parameter int LEN_WIDTH      = 5
) (
    input  logic                      clk,
    input  logic                      ARST,
    input  logic                      par_chk_en,
    input  logic                      sampled_bit,
    input  logic [1:0]                PAR_TYP,
    input  logic [LEN_WIDTH-1:0]      data_len,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic [EDGE_CNT_WIDTH-1:0] edge_cnt,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_STALL,
    input  logic                      clr_err,
    output logic                      par_err,
    output logic                      par_done,
    output logic                      par_err_sticky,
    output logic [ERR_CNT_WIDTH-1:0]  err_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    localparam int CMP_W = (PRESCALE_WIDTH + 1 > EDGE_CNT_WIDTH) ? PRESCALE_WIDTH + 1 : EDGE_CNT_WIDTH;

    state_t                  state;
    logic [PRESCALE_WIDTH:0] chk_pt;
    logic                    hit;
    logic [LEN_WIDTH-1:0]    len_eff;
    logic [DATA_WIDTH-1:0]   masked;
    logic                    exp_bit;
    logic                    err;
    logic                    fire;

    // One extra bit so a maximal Prescale cannot wrap the check point into range.
    assign chk_pt = {1'b0, Prescale >> 1} + (PRESCALE_WIDTH + 1)'(2);
    assign hit    = CMP_W'(edge_cnt) == CMP_W'(chk_pt);

    assign len_eff = (data_len >= LEN_WIDTH'(1) && data_len <= LEN_WIDTH'(DATA_WIDTH))
                     ? data_len : LEN_WIDTH'(DATA_WIDTH);

    always_comb begin
        masked = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            masked[i] = P_DATA[i] & (LEN_WIDTH'(i) < len_eff);
    end

    always_comb begin
        exp_bit = 1'b0;
        case (PAR_TYP)
            2'b00:   exp_bit = ^masked;
            2'b01:   exp_bit = ~(^masked);
            2'b10:   exp_bit = 1'b1;
            default: exp_bit = 1'b0;
        endcase
    end

    assign err  = sampled_bit ^ exp_bit;
    assign fire = (state == ARMED) && par_chk_en && !PAR_STALL && hit;

    always_ff @(posedge clk or posedge ARST) begin
        if (ARST) begin
            state          <= IDLE;
            par_err        <= 1'b0;
            par_done       <= 1'b0;
            par_err_sticky <= 1'b0;
        end else begin
            par_done <= 1'b0;
            case (state)
                IDLE:  if (par_chk_en) state <= ARMED;
                ARMED: begin
                    if (!par_chk_en) begin
                        state <= IDLE;
                    end else if (fire) begin
                        state    <= DONE;
                        par_err  <= err;
                        par_done <= 1'b1;
                    end
                end
                DONE:  if (!par_chk_en) state <= IDLE;
                default: state <= IDLE;
            endcase
            // A coincident clear takes priority over a failing check.
            if (clr_err)
                par_err_sticky <= 1'b0;
            else if (fire && err)
                par_err_sticky <= 1'b1;
        end
    end

`ifdef UART_RX_PAR_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] cnt_q;

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge ARST) begin
        if (ARST)
            cnt_q <= '0;
        else if (clr_err)
            cnt_q <= '0;
        else if (fire && err)
            cnt_q <= sat_inc(cnt_q);
    end

    assign err_cnt = cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: doc/uart_rx_parity_checker.md
Name: uart_rx_parity_checker

Overview:
Parametrised parity checker for the UART receiver. It generalises the 8-bit even/odd checker to:
- a configurable data width
- a runtime frame length
- four parity modes (even, odd, mark, space)
Per frame it runs a one-shot check FSM at the oversampling mid-point and reports the result with a done pulse, a sticky error flag and an optional error counter. It sits between the RX data sampler/deserialiser and the RX FSM/stop-check logic.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame (5..16)
PRESCALE_WIDTH, 6, width of Prescale input
EDGE_CNT_WIDTH, 5, width of edge_cnt input
ERR_CNT_WIDTH, 8, width of the error counter (optional feature)
LEN_WIDTH, 5, width of data_len; must satisfy 2^LEN_WIDTH > DATA_WIDTH

Ports:
clk  in  1  RX oversampling clock
ARST  in  1  async reset, active-high
par_chk_en  in  1  RX FSM is in the parity-bit slot; held for the whole slot
sampled_bit  in  1  majority-voted received bit, valid at the check point
PAR_TYP  in  2  00 even, 01 odd, 10 mark (expect 1), 11 space (expect 0)
data_len  in  LEN_WIDTH  valid data bits in P_DATA (LSB-aligned)
P_DATA  in  DATA_WIDTH  deserialised data word
edge_cnt  in  EDGE_CNT_WIDTH  oversampling edge counter within the current bit
Prescale  in  PRESCALE_WIDTH  oversampling ratio
PAR_STALL  in  1  inhibits the check while high
clr_err  in  1  synchronous clear of sticky flag and counter
par_err  out  1  result of the last completed check; holds until the next check
par_done  out  1  one-cycle pulse: a check has just completed
par_err_sticky  out  1  set by any failing check; cleared only by clr_err or reset
err_cnt  out  ERR_CNT_WIDTH  saturating count of failed checks

Behaviour:
- Reset (ARST=1, async): FSM goes to IDLE. par_err=0, par_done=0, par_err_sticky=0, err_cnt=0.
- Check point: chk_pt = (Prescale>>1)+2.
  - Computed in PRESCALE_WIDTH+1 bits; edge_cnt is zero-extended for the compare.
  - If chk_pt is unreachable by edge_cnt, no check occurs and the FSM waits.
- Effective length: len_eff = data_len when 1 <= data_len <= DATA_WIDTH, else DATA_WIDTH.
- Masked data: bits of P_DATA at index >= len_eff are forced to 0.
- Expected parity bit:
  - even: XOR of masked data
  - odd: inverted XOR of masked data
  - mark: 1
  - space: 0
- err = (sampled_bit != expected).
- FSM states:
  - IDLE -> ARMED when par_chk_en=1.
  - ARMED -> IDLE if par_chk_en=0 (frame aborted; no check).
  - ARMED -> DONE when par_chk_en=1, PAR_STALL=0 and edge_cnt==chk_pt. On this edge: par_err<=err, par_done<=1 (visible the next cycle, latency 1), sticky |= err, err_cnt increments if err.
  - ARMED stays in ARMED when PAR_STALL=1, even at the check point. The check fires at the next matching edge_cnt with PAR_STALL=0.
  - DONE -> IDLE when par_chk_en=0. While in DONE, further check-point matches are ignored (exactly one check per slot).
- par_done is high for exactly one cycle per check. It is 0 in every other cycle.
- par_err keeps its value through IDLE/ARMED and is overwritten only at the next check.
- clr_err (sync):
  - clears par_err_sticky and err_cnt.
  - If it coincides with a failing check, the clear wins for the counter and the sticky flag. par_err still updates.
- err_cnt saturates at all-ones and never wraps.
- PAR_TYP, data_len and P_DATA are sampled only at the check cycle. Changes elsewhere have no effect.
- ARST asserted mid-slot aborts immediately. After release, a new check needs a new par_chk_en (IDLE->ARMED).

Optional Feature:
Macro UART_RX_PAR_ERR_CNT_EN.
- Defined: the err_cnt register and its saturation logic are built as described above.
- Undefined: err_cnt is tied to constant 0 and no counter flops are built. The port stays present. par_err, par_done and par_err_sticky behave identically in both cases.

Test Plan:
- Even mode, Prescale=8 (chk_pt=6), P_DATA=8'hA5, data_len=8, sampled_bit=0, par_chk_en held 16 cycles -> par_done pulses once on the cycle after edge_cnt==6; par_err=0.
- Odd mode, same data, sampled_bit=0 -> par_err=1, par_err_sticky=1, err_cnt=1. A following frame that passes -> par_err=0, sticky stays 1, err_cnt stays 1.
- data_len=5, P_DATA=8'hE1 (masked 5'h01), even mode, sampled_bit=1 -> par_err=0. Repeat with data_len=0 -> treated as 8 (parity of 8'hE1 = 0) -> par_err=1.
- Mark mode with sampled_bit=0 -> par_err=1. Space mode with sampled_bit=0 -> par_err=0. P_DATA contents are irrelevant in both cases.
- PAR_STALL=1 during edge_cnt==6, released before edge_cnt wraps back to 6 -> no done pulse at the first match; the check fires at the second match. Also: par_chk_en dropped before chk_pt -> no par_done, par_err unchanged.
- With the macro defined: 300 consecutive failing frames -> err_cnt saturates at 255. clr_err asserted in the same cycle as a failing check -> err_cnt=0, sticky=0, par_err=1. ARST pulse mid-ARMED -> all outputs 0 asynchronously.
